// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register, write-back data mux and retired-instruction counter.
// Define WB_LOAD_EXT_EN to enable byte/halfword load extraction and sign/zero extension.
module wb_stage #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic [WIDTH-1:0]   mem_aluResult,
  input  logic [WIDTH-1:0]   mem_readData,
  input  logic               mem_memToReg,
  input  logic               mem_regWrite,
  input  logic [REGADDR-1:0] mem_writeReg,
  input  logic [2:0]         mem_loadType,
  output logic [WIDTH-1:0]   outMuxWb,
  output logic               wb_regWrite,
  output logic [REGADDR-1:0] wb_writeReg,
  output logic               wb_valid,
  output logic [31:0]        retired
);

  logic               valid_q;
  logic               mem_to_reg_q;
  logic               reg_write_q;
  logic [WIDTH-1:0]   alu_q;
  logic [WIDTH-1:0]   rdata_q;
  logic [REGADDR-1:0] write_reg_q;
  logic [31:0]        retired_q;
  logic [WIDTH-1:0]   ext_data;

  // Flush kills the control bits but lets the data fields load; stall freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_q        <= '0;
      rdata_q      <= '0;
      write_reg_q  <= '0;
      retired_q    <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_q        <= mem_aluResult;
      rdata_q      <= mem_readData;
      write_reg_q  <= mem_writeReg;
    end else if (!stall) begin
      valid_q      <= mem_valid;
      mem_to_reg_q <= mem_memToReg;
      reg_write_q  <= mem_regWrite;
      alu_q        <= mem_aluResult;
      rdata_q      <= mem_readData;
      write_reg_q  <= mem_writeReg;
      if (mem_valid) begin
        retired_q <= retired_q + 32'd1;
      end
    end
  end

`ifdef WB_LOAD_EXT_EN
  logic [2:0]  load_type_q;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_type_q <= 3'd0;
    end else if (flush || !stall) begin
      load_type_q <= mem_loadType;
    end
  end

  // Little-endian lane select using the effective address low bits.
  always_comb begin
    ld_byte = rdata_q[8*alu_q[1:0] +: 8];
    ld_half = rdata_q[16*alu_q[1] +: 16];
    case (load_type_q)
      3'd1:    ext_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      3'd2:    ext_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      3'd3:    ext_data = {{(WIDTH-8){1'b0}}, ld_byte};
      3'd4:    ext_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ext_data = rdata_q;
    endcase
  end
`else
  logic unused_load_type;
  assign unused_load_type = ^mem_loadType;
  assign ext_data         = rdata_q;
`endif

  assign outMuxWb    = mem_to_reg_q ? ext_data : alu_q;
  assign wb_regWrite = valid_q & reg_write_q & (write_reg_q != '0);
  assign wb_writeReg = write_reg_q;
  assign wb_valid    = valid_q;
  assign retired     = retired_q;

endmodule
